// File: rtl/mshr_file_if.sv
// Miss-status holding register file bundle: load-miss alloc, flush, CHI read request/response, cache refill.
// Pure wiring, no latency of its own.
// Each valid/ready pair follows the usual handshake; chi_resp carries no ready and is always accepted.
interface mshr_file_if #(
  parameter int MSHR_NUM = 4,
  parameter int PADDR_W  = 48,
  parameter int ROBID_W  = 7,
  parameter int LINE_W   = 512
);
  localparam int IDX_W = $clog2(MSHR_NUM);

  logic               alloc_valid;
  logic               alloc_ready;
  logic [PADDR_W-1:0] alloc_paddr;
  logic [ROBID_W-1:0] alloc_robid;
  logic               alloc_merged;
  logic [IDX_W-1:0]   alloc_mshrid;
  logic               flush_valid;
  logic [ROBID_W-1:0] flush_robid;
  logic               chi_req_valid;
  logic               chi_req_ready;
  logic [PADDR_W-1:0] chi_req_paddr;
  logic [IDX_W-1:0]   chi_req_txnid;
  logic               chi_resp_valid;
  logic [IDX_W-1:0]   chi_resp_txnid;
  logic [LINE_W-1:0]  chi_resp_data;
  logic               refill_valid;
  logic               refill_ready;
  logic [PADDR_W-1:0] refill_paddr;
  logic [ROBID_W-1:0] refill_robid;
  logic [IDX_W-1:0]   refill_mshrid;
  logic [LINE_W-1:0]  refill_data;
  logic               busy;

  modport slave (
    input  alloc_valid, alloc_paddr, alloc_robid, flush_valid, flush_robid,
           chi_req_ready, chi_resp_valid, chi_resp_txnid, chi_resp_data, refill_ready,
    output alloc_ready, alloc_merged, alloc_mshrid, chi_req_valid, chi_req_paddr,
           chi_req_txnid, refill_valid, refill_paddr, refill_robid, refill_mshrid,
           refill_data, busy
  );

  modport master (
    output alloc_valid, alloc_paddr, alloc_robid, flush_valid, flush_robid,
           chi_req_ready, chi_resp_valid, chi_resp_txnid, chi_resp_data, refill_ready,
    input  alloc_ready, alloc_merged, alloc_mshrid, chi_req_valid, chi_req_paddr,
           chi_req_txnid, refill_valid, refill_paddr, refill_robid, refill_mshrid,
           refill_data, busy
  );
endinterface

// File: rtl/mshr_file.sv
// Load-miss MSHR file: merges misses per line, issues round-robin line reads, returns refills lowest-index first.
// Latency: alloc -> chi_req next cycle; chi_resp -> refill_valid next cycle (3 cycles minimum alloc to refill).
// Backpressure: alloc_ready drops when full with no line match; chi_req payload held while stalled; refill waits on refill_ready.
module mshr_file #(
  parameter int MSHR_NUM = 4,
  parameter int PADDR_W  = 48,
  parameter int ROBID_W  = 7,
  parameter int LINE_W   = 512
) (
  input logic         clock,
  input logic         reset,
  mshr_file_if.slave  io
);
  localparam int IDX_W = $clog2(MSHR_NUM);
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam logic [PADDR_W-1:0] OFF_MASK = PADDR_W'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {IDLE, S_REQ, W_RESP, S_REFILL} st_e;

  // a is older than b; the MSB is a wrap flag, so differing flags invert the index order
  function automatic logic older(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1]) return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    else                              return a[ROBID_W-2:0] > b[ROBID_W-2:0];
  endfunction

  st_e                state_q [MSHR_NUM];
  st_e                state_d [MSHR_NUM];
  logic               killed_q [MSHR_NUM];
  logic               killed_d [MSHR_NUM];
  logic [PADDR_W-1:0] paddr_q [MSHR_NUM];
  logic [PADDR_W-1:0] paddr_d [MSHR_NUM];
  logic [ROBID_W-1:0] robid_q [MSHR_NUM];
  logic [ROBID_W-1:0] robid_d [MSHR_NUM];
  logic [LINE_W-1:0]  data_q [MSHR_NUM];
  logic [LINE_W-1:0]  data_d [MSHR_NUM];
  logic [ROBID_W-1:0] merged_robid [MSHR_NUM];
  logic               kill [MSHR_NUM];

  logic [IDX_W-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, probe;
  logic             lock_q, lock_d;
  logic             match_hit, free_hit, req_hit, ref_hit, busy_w, alloc_ready_w;
  logic [IDX_W-1:0] match_idx, free_idx, req_idx, ref_idx;
  logic             alloc_fire, req_fire, refill_fire, flush_new;

  // Entry selection: line match, first free, flush kill mask, round-robin request winner, refill winner
  always_comb begin
    match_hit = 1'b0; match_idx = '0;
    free_hit  = 1'b0; free_idx  = '0;
    req_hit   = 1'b0; req_idx   = '0;
    ref_hit   = 1'b0; ref_idx   = '0;
    busy_w    = 1'b0; probe     = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (!free_hit && state_q[i] == IDLE) begin
        free_hit = 1'b1; free_idx = IDX_W'(i);
      end
      if (!match_hit && state_q[i] != IDLE && !killed_q[i] &&
          paddr_q[i][PADDR_W-1:OFF] == io.alloc_paddr[PADDR_W-1:OFF]) begin
        match_hit = 1'b1; match_idx = IDX_W'(i);
      end
      if (state_q[i] != IDLE) busy_w = 1'b1;
    end
    // Flush judges the robid as it stands after this cycle's merge
    for (int i = 0; i < MSHR_NUM; i++) begin
      merged_robid[i] = (io.alloc_valid && match_hit && match_idx == IDX_W'(i) &&
                         older(io.alloc_robid, robid_q[i])) ? io.alloc_robid : robid_q[i];
      kill[i] = io.flush_valid && older(io.flush_robid, merged_robid[i]);
      if (!ref_hit && state_q[i] == S_REFILL && !kill[i]) begin
        ref_hit = 1'b1; ref_idx = IDX_W'(i);
      end
    end
    for (int k = 0; k < MSHR_NUM; k++) begin
      probe = rr_q + IDX_W'(k);
      if (!req_hit && state_q[probe] == S_REQ && !kill[probe]) begin
        req_hit = 1'b1; req_idx = probe;
      end
    end
    // A stalled request keeps its winner so the payload cannot change under the consumer
    if (lock_q && state_q[lock_idx_q] == S_REQ && !kill[lock_idx_q]) begin
      req_hit = 1'b1; req_idx = lock_idx_q;
    end
  end

  assign alloc_ready_w = match_hit | free_hit;
  assign alloc_fire    = io.alloc_valid & alloc_ready_w;
  assign req_fire      = req_hit & io.chi_req_ready;
  assign refill_fire   = ref_hit & io.refill_ready;
  assign flush_new     = io.flush_valid & older(io.flush_robid, io.alloc_robid);

  assign io.alloc_ready   = alloc_ready_w;
  assign io.alloc_merged  = io.alloc_valid & match_hit;
  assign io.alloc_mshrid  = match_hit ? match_idx : free_idx;
  assign io.chi_req_valid = req_hit;
  assign io.chi_req_paddr = paddr_q[req_idx];
  assign io.chi_req_txnid = req_idx;
  assign io.refill_valid  = ref_hit;
  assign io.refill_paddr  = paddr_q[ref_idx];
  assign io.refill_robid  = merged_robid[ref_idx];
  assign io.refill_mshrid = ref_idx;
  assign io.refill_data   = data_q[ref_idx];
  assign io.busy          = busy_w;

  // Per-entry next state; flush overrides issue/refill handshakes on the same entry
  always_comb begin
    rr_d       = req_fire ? req_idx + IDX_W'(1) : rr_q;
    lock_d     = req_hit & ~io.chi_req_ready;
    lock_idx_d = req_idx;
    for (int i = 0; i < MSHR_NUM; i++) begin
      state_d[i]  = state_q[i];
      killed_d[i] = killed_q[i];
      paddr_d[i]  = paddr_q[i];
      robid_d[i]  = merged_robid[i];
      data_d[i]   = data_q[i];
      case (state_q[i])
        IDLE: begin
          if (alloc_fire && !match_hit && free_idx == IDX_W'(i) && !flush_new) begin
            state_d[i]  = S_REQ;
            killed_d[i] = 1'b0;
            paddr_d[i]  = io.alloc_paddr & ~OFF_MASK;
            robid_d[i]  = io.alloc_robid;
          end
        end
        S_REQ: begin
          if (kill[i])                                 state_d[i] = IDLE;
          else if (req_fire && req_idx == IDX_W'(i))   state_d[i] = W_RESP;
        end
        W_RESP: begin
          if (io.chi_resp_valid && io.chi_resp_txnid == IDX_W'(i)) begin
            data_d[i]   = io.chi_resp_data;
            state_d[i]  = (killed_q[i] || kill[i]) ? IDLE : S_REFILL;
            killed_d[i] = 1'b0;
          end else if (kill[i]) begin
            killed_d[i] = 1'b1;
          end
        end
        S_REFILL: begin
          if (kill[i] || (refill_fire && ref_idx == IDX_W'(i))) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset abandoning every entry
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < MSHR_NUM; i++) begin
        state_q[i]  <= IDLE;
        killed_q[i] <= 1'b0;
        paddr_q[i]  <= '0;
        robid_q[i]  <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < MSHR_NUM; i++) begin
        state_q[i]  <= state_d[i];
        killed_q[i] <= killed_d[i];
        paddr_q[i]  <= paddr_d[i];
        robid_q[i]  <= robid_d[i];
        data_q[i]   <= data_d[i];
      end
    end
  end
endmodule
